// File: rtl/ppm_rx_decoder.sv
// PPM optical receiver: preamble lock, slot-timed symbol decode
// and a small output word FIFO.
module ppm_rx_decoder #(
    parameter int PULSE_CT   = 7500,
    parameter int N_MOD      = 2,
    parameter int L          = 10000,
    parameter int N_PKT      = 8,
    parameter int PRE_CT     = 4,
    parameter int DELTA      = 2000,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          pulse,
    input  logic                          read,
    output logic [N_PKT-1:0]              data,
    output logic                          avail,
    output logic                          locked,
    output logic                          err,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   count
);

    localparam int SYMS = N_PKT / N_MOD;
    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int SP_W = $clog2(L + DELTA + 2);
    localparam int PC_W = $clog2(PRE_CT + 1);
    localparam int LW   = $clog2(L);
    localparam int SC_W = $clog2(SYMS + 1);

    localparam logic [SP_W-1:0] SP_LO   = SP_W'(L - DELTA);
    localparam logic [SP_W-1:0] SP_HI   = SP_W'(L + DELTA);
    localparam logic [SP_W-1:0] SP_TO   = SP_W'(L + DELTA + 1);
    localparam logic [PC_W-1:0] PC_LAST = PC_W'(PRE_CT - 1);
    localparam logic [LW-1:0]   L_LAST  = LW'(L - 1);
    localparam logic [SC_W-1:0] SC_LAST = SC_W'(SYMS - 1);
    localparam logic [PW:0]     FULL    = (PW + 1)'(FIFO_DEPTH);

    generate
        if (PULSE_CT >= L || PRE_CT < 2 || 2 * DELTA >= L ||
            N_PKT % N_MOD != 0 || FIFO_DEPTH < 2 ||
            (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
            $error("ppm_rx_decoder: illegal parameter set");
        end
    endgenerate

    typedef enum logic [1:0] {HUNT, PRE, GAP, DATA} state_t;

    state_t state, state_n;

    logic s1, s2, s3, rise;

    logic [SP_W-1:0]  sp, sp_n;
    logic [PC_W-1:0]  pre, pre_n;
    logic [LW-1:0]    gap, gap_n;
    logic [LW-1:0]    intra, intra_n;
    logic [N_MOD-1:0] slot, slot_n;
    logic [SC_W-1:0]  sym, sym_n;
    logic             got, got_n;
    logic [N_PKT-1:0] sh, sh_n;
    logic             err_n;
    logic             push;
    logic             win_end;

    logic [N_PKT-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]    wp, rp;
    logic             pop, wr, full;

    // rise is registered so it trails the raw input by three edges
    always_ff @(posedge clk) begin
        if (rst) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            s3   <= 1'b0;
            rise <= 1'b0;
        end else begin
            s1   <= pulse;
            s2   <= s1;
            s3   <= s2;
            rise <= s2 & ~s3;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= HUNT;
            sp    <= '0;
            pre   <= '0;
            gap   <= '0;
            intra <= '0;
            slot  <= '0;
            sym   <= '0;
            got   <= 1'b0;
            sh    <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_n;
            sp    <= sp_n;
            pre   <= pre_n;
            gap   <= gap_n;
            intra <= intra_n;
            slot  <= slot_n;
            sym   <= sym_n;
            got   <= got_n;
            sh    <= sh_n;
            err   <= err_n;
        end
    end

    always_comb begin
        state_n = state;
        sp_n    = sp;
        pre_n   = pre;
        gap_n   = gap;
        intra_n = intra;
        slot_n  = slot;
        sym_n   = sym;
        got_n   = got;
        sh_n    = sh;
        err_n   = 1'b0;
        push    = 1'b0;
        win_end = 1'b0;
        unique case (state)
            HUNT: begin
                sp_n    = '0;
                pre_n   = '0;
                gap_n   = '0;
                intra_n = '0;
                slot_n  = '0;
                sym_n   = '0;
                got_n   = 1'b0;
                sh_n    = '0;
                if (rise) begin
                    state_n = PRE;
                    sp_n    = SP_W'(1);
                    pre_n   = PC_W'(1);
                end
            end
            PRE: begin
                sp_n = sp + 1'b1;
                if (rise) begin
                    if (sp < SP_LO || sp > SP_HI) begin
                        pre_n = PC_W'(1);
                        sp_n  = SP_W'(1);
                    end else if (pre == PC_LAST) begin
                        state_n = GAP;
                        pre_n   = pre + 1'b1;
                        gap_n   = LW'(1);
                    end else begin
                        pre_n = pre + 1'b1;
                        sp_n  = SP_W'(1);
                    end
                end else if (sp == SP_TO) begin
                    state_n = HUNT;
                    pre_n   = '0;
                    sp_n    = '0;
                end
            end
            GAP: begin
                if (gap == L_LAST) begin
                    state_n = DATA;
                    gap_n   = '0;
                    intra_n = '0;
                    slot_n  = '0;
                    sym_n   = '0;
                    got_n   = 1'b0;
                    sh_n    = '0;
                end else begin
                    gap_n = gap + 1'b1;
                end
            end
            DATA: begin
                win_end = (intra == L_LAST) && (slot == '1);
                if (intra == L_LAST) begin
                    intra_n = '0;
                    slot_n  = slot + 1'b1;
                end else begin
                    intra_n = intra + 1'b1;
                end
                got_n = win_end ? 1'b0 : got;
                if (rise && !got) begin
                    sh_n  = N_PKT'({sh, slot});
                    sym_n = sym + 1'b1;
                    if (!win_end) got_n = 1'b1;
                    if (sym == SC_LAST) begin
                        push    = 1'b1;
                        state_n = HUNT;
                    end
                end else if (win_end && !got) begin
                    err_n   = 1'b1;
                    state_n = HUNT;
                end
            end
            default: state_n = HUNT;
        endcase
    end

    assign locked = (state == GAP) || (state == DATA);

    assign avail = count != '0;
    assign full  = count == FULL;
    assign pop   = read && avail;
    assign wr    = push && (!full || pop);
    assign data  = mem[rp];

    always_ff @(posedge clk) begin
        if (rst) begin
            wp       <= '0;
            rp       <= '0;
            count    <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (wr) begin
                mem[wp] <= sh_n;
                wp      <= wp + 1'b1;
            end
            if (pop) rp <= rp + 1'b1;
            if (wr && !pop) count <= count + 1'b1;
            else if (!wr && pop) count <= count - 1'b1;
            if (push && !wr) overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ppm_rx_decoder.sv
// Randomised bench for ppm_rx_decoder against a timestamp-based
// reference model of lock, symbol windows and the word FIFO.
module tb_ppm_rx_decoder;

    localparam int L     = 20;
    localparam int PCT   = 5;
    localparam int N_MOD = 2;
    localparam int N_PKT = 8;
    localparam int PRE_N = 4;
    localparam int DELTA = 3;
    localparam int FD    = 4;
    localparam int SYMS  = N_PKT / N_MOD;
    localparam int WIN   = L * (1 << N_MOD);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             pulse = 1'b0;
    logic             read = 1'b0;
    logic [N_PKT-1:0] data;
    logic             avail, locked, err, overflow;
    logic [$clog2(FD):0] count;

    ppm_rx_decoder #(
        .PULSE_CT(PCT), .N_MOD(N_MOD), .L(L), .N_PKT(N_PKT),
        .PRE_CT(PRE_N), .DELTA(DELTA), .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk), .rst(rst), .pulse(pulse), .read(read),
        .data(data), .avail(avail), .locked(locked), .err(err),
        .overflow(overflow), .count(count)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int err_seen = 0;

    int rises[$];
    int sym_q[SYMS];
    int words[$];

    // reference model state: 0 hunt, 1 preamble, 2 gap, 3 data
    bit hist[$];
    int cyc = 0;
    int last_rst = -100;
    int m_mode = 0;
    int m_tlast, m_npre, m_tlock, m_t0, m_nsym, m_word;
    bit m_got, m_err, m_ovf;
    int mq[$];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    task automatic model_step();
        bit e, pop, psh, last;
        int off, slotv, w, d;
        psh = 1'b0;
        w   = 0;
        hist.push_back(rst ? 1'b0 : pulse);
        e = (cyc >= 4) && (cyc - last_rst >= 4) &&
            hist[cyc-3] && !hist[cyc-4];
        if (rst) begin
            m_mode   = 0;
            m_err    = 1'b0;
            m_ovf    = 1'b0;
            m_got    = 1'b0;
            mq.delete();
            last_rst = cyc;
        end else begin
            m_err = 1'b0;
            pop = read && (mq.size() > 0);
            case (m_mode)
                0: if (e) begin
                    m_mode  = 1;
                    m_tlast = cyc;
                    m_npre  = 1;
                end
                1: begin
                    d = cyc - m_tlast;
                    if (e) begin
                        if (d >= L - DELTA && d <= L + DELTA) begin
                            m_npre++;
                            m_tlast = cyc;
                            if (m_npre == PRE_N) begin
                                m_mode  = 2;
                                m_tlock = cyc;
                            end
                        end else begin
                            m_npre  = 1;
                            m_tlast = cyc;
                        end
                    end else if (d == L + DELTA + 1) begin
                        m_mode = 0;
                    end
                end
                2: if (cyc - m_tlock == L) begin
                    m_mode = 3;
                    m_t0   = cyc;
                    m_got  = 1'b0;
                    m_nsym = 0;
                    m_word = 0;
                end
                default: ;
            endcase
            if (m_mode == 3) begin
                off   = cyc - m_t0;
                slotv = (off / L) % (1 << N_MOD);
                last  = (off % WIN) == WIN - 1;
                if (e && !m_got) begin
                    m_word = ((m_word << N_MOD) | slotv) & ((1 << N_PKT) - 1);
                    m_nsym++;
                    m_got = 1'b1;
                    if (m_nsym == SYMS) begin
                        psh    = 1'b1;
                        w      = m_word;
                        m_mode = 0;
                    end
                end
                if (m_mode == 3 && last) begin
                    if (!m_got) begin
                        m_err  = 1'b1;
                        m_mode = 0;
                    end else begin
                        m_got = 1'b0;
                    end
                end
            end
            if (pop) void'(mq.pop_front());
            if (psh) begin
                if (mq.size() < FD) mq.push_back(w);
                else m_ovf = 1'b1;
            end
        end
        cyc++;
    endtask

    task automatic tick();
        logic [3:0] ef;
        @(posedge clk);
        model_step();
        #1;
        ef = {mq.size() != 0, m_mode >= 2, m_err, m_ovf};
        chk("count", 32'(count), 32'(mq.size()));
        chk("flags", {avail, locked, err, overflow}, ef);
        if (mq.size() != 0) chk("data", data, mq[0]);
    endtask

    function automatic bit wave_at(input int t);
        for (int i = 0; i < rises.size(); i++) begin
            int w = PCT;
            if (i + 1 < rises.size() && rises[i+1] - rises[i] - 1 < w)
                w = rises[i+1] - rises[i] - 1;
            if (t >= rises[i] && t < rises[i] + w) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic play(input int len, input int rd_mode,
                        input int rd_at, input int rst_at);
        for (int t = 0; t < len; t++) begin
            pulse = wave_at(t);
            read  = (t == rd_at) ||
                    (rd_mode == 1 && $urandom_range(0, 3) == 0);
            rst   = (t == rst_at);
            tick();
            if (err === 1'b1) err_seen++;
        end
        pulse = 1'b0;
        read  = 1'b0;
        rst   = 1'b0;
        rises.delete();
    endtask

    task automatic add_pre(input int base, input int n);
        for (int i = 0; i < n; i++) rises.push_back(base + L * i);
    endtask

    task automatic add_syms(input int lr, input int nsym, input int jmax);
        for (int i = 0; i < nsym; i++) begin
            int j = (jmax > 0) ? int'($urandom_range(0, jmax)) : 0;
            int r = lr + L + WIN * i + L * sym_q[i] + j;
            rises.push_back(r);
            if (jmax > 0 && i < nsym - 1 && sym_q[i] <= 1 && j <= 10 &&
                $urandom_range(0, 1) == 1)
                rises.push_back(r + 25);
        end
    endtask

    task automatic rand_syms();
        for (int i = 0; i < SYMS; i++) sym_q[i] = $urandom_range(0, 3);
    endtask

    function automatic int pkt_word();
        int w = 0;
        for (int i = 0; i < SYMS; i++) w = (w << N_MOD) | sym_q[i];
        return w;
    endfunction

    initial begin
        int base, nsym, rst_at, rd_at;

        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        chk("rst_data", data, 0);
        chk("rst_count", 32'(count), 0);

        // four clean preamble pulses then symbols 2,1,3,0
        sym_q = '{2, 1, 3, 0};
        add_pre(0, PRE_N);
        add_syms(60, SYMS, 0);
        play(330, 0, -1, -1);
        chk("r38_data", data, 8'h9C);
        chk("r38_count", 32'(count), 1);
        chk("r38_avail", avail, 1);
        play(2, 0, 0, -1);

        // short spacing mid-preamble restarts the lock count
        rand_syms();
        foreach (rises[i]) ;
        rises.push_back(0);
        rises.push_back(20);
        rises.push_back(40);
        rises.push_back(54);
        rises.push_back(74);
        rises.push_back(94);
        rises.push_back(114);
        add_syms(114, SYMS, 15);
        play(114 + L + 3 * WIN + 4 * L + 10, 0, -1, -1);
        chk("r39_data", data, pkt_word());
        chk("r39_count", 32'(count), 1);
        play(2, 0, 0, -1);

        // two symbols then silence: one err pulse, lock dropped
        rand_syms();
        add_pre(0, PRE_N);
        add_syms(60, 2, 15);
        err_seen = 0;
        play(360, 0, -1, -1);
        chk("r40_err", err_seen, 1);
        chk("r40_lock", locked, 0);
        chk("r40_count", 32'(count), 0);

        // five packets with no reads: overflow, head is first word
        words.delete();
        for (int k = 0; k < 5; k++) begin
            rand_syms();
            add_pre(k * 420, PRE_N);
            add_syms(k * 420 + 60, SYMS, 15);
            words.push_back(pkt_word());
        end
        play(5 * 420, 0, -1, -1);
        chk("r41_count", 32'(count), 4);
        chk("r41_ovf", overflow, 1);
        for (int i = 0; i < 4; i++) begin
            chk("r41_rd", data, words[i]);
            play(1, 0, 0, -1);
        end
        chk("r41_avail", avail, 0);

        // full FIFO with the last symbol landing on a read
        play(2, 0, -1, 0);
        words.delete();
        for (int k = 0; k < 5; k++) begin
            rand_syms();
            add_pre(k * 420, PRE_N);
            add_syms(k * 420 + 60, SYMS, 15);
            words.push_back(pkt_word());
        end
        rd_at = rises[rises.size()-1] + 3;
        play(5 * 420, 0, rd_at, -1);
        chk("r42_count", 32'(count), 4);
        chk("r42_ovf", overflow, 0);
        for (int i = 0; i < 4; i++) begin
            chk("r42_rd", data, words[i+1]);
            play(1, 0, 0, -1);
        end

        // reset inside data window 1 with a word already queued
        play(2, 0, -1, 0);
        rand_syms();
        add_pre(0, PRE_N);
        add_syms(60, SYMS, 15);
        play(420, 0, -1, -1);
        chk("r43_pre", 32'(count), 1);
        rand_syms();
        add_pre(0, PRE_N);
        add_syms(60, 1, 0);
        play(180, 0, -1, 60 + 3 + L + WIN + 10);
        chk("r43_flags", {avail, locked, err, overflow}, 4'b0000);
        chk("r43_count", 32'(count), 0);
        chk("r43_data", data, 0);
        rand_syms();
        add_pre(0, PRE_N);
        add_syms(60, SYMS, 15);
        play(420, 0, -1, -1);
        chk("r43_word", data, pkt_word());
        chk("r43_cnt1", 32'(count), 1);
        play(2, 0, 0, -1);

        // randomised traffic: noise, dropped symbols, resets, reads
        for (int k = 0; k < 40; k++) begin
            rand_syms();
            base = 0;
            if ($urandom_range(0, 3) == 0) begin
                rises.push_back(0);
                base = 40;
            end
            nsym = ($urandom_range(0, 5) == 0) ?
                   int'($urandom_range(1, 3)) : SYMS;
            add_pre(base, PRE_N);
            add_syms(base + 60, nsym, 15);
            rst_at = ($urandom_range(0, 9) == 0) ?
                     int'($urandom_range(0, 300)) : -1;
            play(base + 440, 1, -1, rst_at);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/ppm_rx_decoder.md
PPM_RX_DECODER -- requirements
Module: ppm_rx_decoder

Interface
REQ-001 Param PULSE_CT, 7500: nominal pulse high-time in clk cycles; SHALL be < L.
REQ-002 Param N_MOD, 2: bits per PPM symbol; one symbol window = 2^N_MOD slots.
REQ-003 Param L, 10000: slot length and preamble pulse period in clk cycles.
REQ-004 Param N_PKT, 8: payload bits per word; SHALL be an integer multiple of N_MOD.
REQ-005 Param PRE_CT, 4: consecutive preamble pulses required for lock; SHALL be >= 2.
REQ-006 Param DELTA, 2000: preamble spacing tolerance in cycles; SHALL be < L/2.
REQ-007 Param FIFO_DEPTH, 4: output word buffer depth; SHALL be a power of two, >= 2.
REQ-008 Port clk, in, 1: single clock; all state changes on its rising edge.
REQ-009 Port rst, in, 1: synchronous, active-high reset.
REQ-010 Port pulse, in, 1: asynchronous photodiode input; high = light.
REQ-011 Port read, in, 1: consumer pops head word when read && avail.
REQ-012 Port data, out, N_PKT: FIFO head word; valid only while avail.
REQ-013 Port avail, out, 1: FIFO non-empty.
REQ-014 Port locked, out, 1: high in GAP and DATA states.
REQ-015 Port err, out, 1: one-cycle pulse on symbol timeout.
REQ-016 Port overflow, out, 1: sticky; set when a completed word is dropped.
REQ-017 Port count, out, clog2(FIFO_DEPTH)+1: words currently in FIFO.

Function
REQ-018 pulse SHALL pass a 2-flop synchronizer; a rising edge SHALL be flagged internally ("edge") exactly 3 cycles after raw rise; only rising edges are timed.
REQ-019 FSM states: HUNT, PRE, GAP, DATA.
REQ-020 HUNT: on edge -> PRE, pre_cnt=1, spacing counter cleared.
REQ-021 PRE: edge with spacing in [L-DELTA, L+DELTA] -> pre_cnt+1; on reaching PRE_CT -> GAP, gap counter cleared.
REQ-022 PRE: edge with spacing < L-DELTA -> stay PRE, pre_cnt=1, spacing restarts from this edge.
REQ-023 PRE: spacing counter reaching L+DELTA+1 with no edge -> HUNT, pre_cnt=0.
REQ-024 GAP: edges ignored; after L cycles from last preamble edge -> DATA, window 0 starts.
REQ-025 DATA: each window is 2^N_MOD*L cycles; offset tracked by slot counter (0..2^N_MOD-1) and intra-slot counter (0..L-1); no divider.
REQ-026 First edge in a window: symbol = current slot counter value; shifted into word MSB-first; further edges in same window ignored.
REQ-027 Window boundaries are fixed from GAP exit (no realignment); next window starts on schedule regardless of edge position.
REQ-028 Window ending with no edge: err=1 for one cycle, partial word discarded, -> HUNT.
REQ-029 Edge completing symbol N_PKT/N_MOD: word pushed at end of that cycle, FSM -> HUNT same edge; avail high next cycle.
REQ-030 Push while full and no simultaneous pop: word dropped, FIFO unchanged, overflow set.
REQ-031 Push and pop in same cycle while full: both performed, count unchanged, no overflow.
REQ-032 read while !avail: ignored, no state change.
REQ-033 data SHALL be registered/head-indexed so it changes only on push-into-empty or pop.
REQ-034 Pointers SHALL wrap modulo FIFO_DEPTH; count = full width, 0..FIFO_DEPTH.

Reset
REQ-035 rst SHALL force: FSM HUNT, all counters 0, FIFO empty, avail=0, count=0, locked=0, err=0, overflow=0, data=0, synchronizer flops 0.
REQ-036 rst mid-packet SHALL discard partial word and FIFO contents; no err pulse.
REQ-037 rst SHALL take priority over read and edge in the same cycle.

Verification (L=20, PULSE_CT=5, N_MOD=2, N_PKT=8, PRE_CT=4, DELTA=3, FIFO_DEPTH=4)
REQ-038 4 pulses spaced 20 cycles, then symbols 2,1,3,0 (edges at slot starts) -> locked after 4th edge, data=8'h9C, avail=1, count=1.
REQ-039 Preamble spacings 20,20,14,20,20,20 -> lock only after edge 7 (restart at short gap), word decoded correctly.
REQ-040 Lock, send 2 symbols, no pulse for 80 cycles -> err one cycle, locked=0, count unchanged.
REQ-041 Send 5 packets, read=0 -> count=4, overflow=1, head = first word; read 4 times -> words in order, avail=0.
REQ-042 FIFO full, final symbol edge coincident with read -> count stays 4, overflow=0, new word at tail.
REQ-043 rst during DATA window 1 -> all outputs zero next cycle; fresh packet decodes normally afterwards.
